// File: rtl/turnstile_credit_controller.sv
// turnstile_credit_controller: coin/push turnstile with multi-coin pricing,
// banked credits, coin refund on saturation, timed alarm and pass counter.
// Ports: clk, rst (sync, active-high), coin, push (1-cycle pulses) in;
// locked, alarm, credit, coin_reject, timeout, pass_count out (registered).
// Optional: define TURNSTILE_IDLE_TIMEOUT_EN to build the idle relock timer;
// without it credit never expires and timeout is tied to 0.
module turnstile_credit_controller #(
  parameter int PRICE        = 1,
  parameter int MAX_CREDIT   = 3,
  parameter int CREDIT_W     = 4,
  parameter int ALARM_CYCLES = 2,
  parameter int TIMEOUT      = 16,
  parameter int COUNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin,
  input  logic                push,
  output logic                locked,
  output logic                alarm,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                timeout,
  output logic [COUNT_W-1:0]  pass_count
);

  localparam int AW = (PRICE > 1) ? $clog2(PRICE) : 1;
  localparam int TW = $clog2(ALARM_CYCLES + 1);

  localparam logic [CREDIT_W-1:0] MAXC   = CREDIT_W'(MAX_CREDIT);
  localparam logic [AW:0]         PRICEV = (AW+1)'(PRICE);
  localparam logic [TW-1:0]       ALMV   = TW'(ALARM_CYCLES);

  typedef enum logic {
    S_LOCKED,
    S_OPEN
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [TW-1:0]       alm_q, alm_d;
  logic                alarm_q, alarm_d;
  logic                rej_q, rej_d;
  logic [COUNT_W-1:0]  pass_q, pass_d;

  logic                legal;
  logic                illegal;
  logic [CREDIT_W-1:0] cred_ap;
  logic [AW:0]         acc_inc;

`ifdef TURNSTILE_IDLE_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] TOV = IW'(TIMEOUT);

  logic [IW-1:0] idle_q, idle_d;
  logic          to_q, to_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
      to_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      to_q   <= to_d;
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOCKED;
      credit_q <= '0;
      acc_q    <= '0;
      alm_q    <= '0;
      alarm_q  <= 1'b0;
      rej_q    <= 1'b0;
      pass_q   <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      acc_q    <= acc_d;
      alm_q    <= alm_d;
      alarm_q  <= alarm_d;
      rej_q    <= rej_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    legal    = push && (credit_q != '0);
    illegal  = push && (credit_q == '0);
    // push is judged against the old credit before any coin lands
    cred_ap  = credit_q - CREDIT_W'(legal);
    acc_inc  = {1'b0, acc_q} + (AW+1)'(1);
    credit_d = cred_ap;
    acc_d    = acc_q;
    rej_d    = 1'b0;
    pass_d   = pass_q;
    alm_d    = alm_q;

    if (legal) begin
      pass_d = pass_q + COUNT_W'(1);
    end

    if (illegal) begin
      alm_d = ALMV;
    end else if (legal) begin
      alm_d = '0;
    end else if (alm_q != '0) begin
      alm_d = alm_q - TW'(1);
    end

    if (coin) begin
      if (acc_inc == PRICEV) begin
        if (cred_ap < MAXC) begin
          credit_d = cred_ap + CREDIT_W'(1);
          acc_d    = '0;
        end else begin
          // refund: the completing coin is dropped, accumulator untouched
          rej_d = 1'b1;
        end
      end else begin
        acc_d = acc_inc[AW-1:0];
      end
    end

`ifdef TURNSTILE_IDLE_TIMEOUT_EN
    idle_d = '0;
    to_d   = 1'b0;
    if ((credit_q != '0) && !coin && !push) begin
      idle_d = idle_q + IW'(1);
      if (idle_d == TOV) begin
        idle_d   = '0;
        credit_d = '0;
        acc_d    = '0;
        to_d     = 1'b1;
      end
    end
`endif

    alarm_d = (alm_d != '0);
    state_d = (credit_d == '0) ? S_LOCKED : S_OPEN;
  end

  assign locked      = (state_q == S_LOCKED);
  assign alarm       = alarm_q;
  assign credit      = credit_q;
  assign coin_reject = rej_q;
  assign pass_count  = pass_q;

endmodule

// File: tb/tb_turnstile_credit_controller.sv
// Testbench for turnstile_credit_controller: directed scenarios plus
// randomized traffic checked against a cycle-level reference model.
module tb_turnstile_credit_controller;

  localparam int PRICE = 2;
  localparam int MAXC  = 2;
  localparam int CW    = 4;
  localparam int ALC   = 3;
  localparam int TO    = 8;
  localparam int PW    = 4;

`ifdef TURNSTILE_IDLE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          coin;
  logic          push;
  logic          locked;
  logic          alarm;
  logic [CW-1:0] credit;
  logic          coin_reject;
  logic          timeout;
  logic [PW-1:0] pass_count;

  int n_vec;
  int n_err;

  // reference model state
  int m_credit;
  int m_acc;
  int m_idle;
  int m_pass;
  int m_cyc;
  int m_alarm_last;
  bit m_rej;
  bit m_to;

  turnstile_credit_controller #(
    .PRICE(PRICE),
    .MAX_CREDIT(MAXC),
    .CREDIT_W(CW),
    .ALARM_CYCLES(ALC),
    .TIMEOUT(TO),
    .COUNT_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .coin(coin),
    .push(push),
    .locked(locked),
    .alarm(alarm),
    .credit(credit),
    .coin_reject(coin_reject),
    .timeout(timeout),
    .pass_count(pass_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model(input bit r, input bit c, input bit p);
    int cr0;
    int cap;
    int nc;
    m_cyc++;
    m_rej = 1'b0;
    m_to  = 1'b0;
    if (r) begin
      m_credit     = 0;
      m_acc        = 0;
      m_idle       = 0;
      m_pass       = 0;
      m_alarm_last = -1;
    end else begin
      cr0 = m_credit;
      cap = cr0;
      if (p && cr0 > 0) begin
        cap          = cr0 - 1;
        m_pass       = (m_pass + 1) % (1 << PW);
        m_alarm_last = -1;
      end else if (p) begin
        // alarm visible after this edge and the next ALC-1 edges
        m_alarm_last = m_cyc + ALC - 1;
      end
      nc = cap;
      if (c) begin
        if (m_acc + 1 == PRICE) begin
          if (cap < MAXC) begin
            nc    = cap + 1;
            m_acc = 0;
          end else begin
            m_rej = 1'b1;
          end
        end else begin
          m_acc = m_acc + 1;
        end
      end
      if (TO_EN) begin
        if (cr0 > 0 && !c && !p) begin
          m_idle++;
          if (m_idle == TO) begin
            nc     = 0;
            m_acc  = 0;
            m_to   = 1'b1;
            m_idle = 0;
          end
        end else begin
          m_idle = 0;
        end
      end
      m_credit = nc;
    end
  endtask

  function automatic logic [11:0] exp_vec();
    logic [CW-1:0] cr;
    logic [PW-1:0] pc;
    cr = CW'(m_credit);
    pc = PW'(m_pass);
    return {m_credit == 0, m_cyc <= m_alarm_last, cr, m_rej, m_to, pc};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {locked, alarm, credit, coin_reject, timeout, pass_count};
  endfunction

  task automatic step(input bit r, input bit c, input bit p);
    rst  = r;
    coin = c;
    push = p;
    @(posedge clk);
    model(r, c, p);
    #1;
    rst  = 1'b0;
    coin = 1'b0;
    push = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    n_vec++;
    if (obs_vec() !== 12'h800) begin
      n_err++;
      $display("FAIL reset_vals: got %h want 800", obs_vec());
    end
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (alarm !== (i < ALC) || locked !== 1'b1) begin
        n_err++;
        $display("FAIL alarm_len c%0d: got a%b l%b want a%b l1",
                 i, alarm, locked, i < ALC);
      end
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL alarm_model c%0d: got %h want %h",
                 i, obs_vec(), exp_vec());
      end
      step(0, 0, 0);
    end
  endtask

  task automatic test_coin_price();
    step(0, 1, 0);
    step(0, 0, 0);
    n_vec++;
    if (credit !== 4'd0 || locked !== 1'b1) begin
      n_err++;
      $display("FAIL partial_coin: got c%0d l%b want c0 l1", credit, locked);
    end
    step(0, 1, 0);
    n_vec++;
    if (credit !== 4'd1 || locked !== 1'b0) begin
      n_err++;
      $display("FAIL full_price: got c%0d l%b want c1 l0", credit, locked);
    end
    step(0, 0, 1);
    n_vec++;
    if (obs_vec() !== 12'h801) begin
      n_err++;
      $display("FAIL legal_pass: got %h want 801", obs_vec());
    end
  endtask

  task automatic test_saturation();
    int rej;
    rej = 0;
    step(1, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      step(0, 1, 0);
      if (coin_reject === 1'b1) rej++;
      n_vec++;
      if (coin_reject !== (k == 6)) begin
        n_err++;
        $display("FAIL reject_at k%0d: got %b want %b",
                 k, coin_reject, k == 6);
      end
      if (k == 4) begin
        n_vec++;
        if (credit !== 4'd2) begin
          n_err++;
          $display("FAIL sat_fill: got %0d want 2", credit);
        end
      end
      step(0, 0, 0);
      if (coin_reject === 1'b1) rej++;
    end
    n_vec++;
    if (rej != 1 || credit !== 4'd2) begin
      n_err++;
      $display("FAIL sat_total: got rej%0d c%0d want rej1 c2", rej, credit);
    end
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL sat_model: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    n_vec++;
    if (credit !== 4'd1 || pass_count !== 4'd1 || alarm !== 1'b0) begin
      n_err++;
      $display("FAIL simul_legal: got c%0d p%0d a%b want c1 p1 a0",
               credit, pass_count, alarm);
    end
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    n_vec++;
    if (credit !== 4'd1 || alarm !== 1'b1 || pass_count !== 4'd2
        || locked !== 1'b0) begin
      n_err++;
      $display("FAIL simul_illegal: got c%0d a%b p%0d l%b want c1 a1 p2 l0",
               credit, alarm, pass_count, locked);
    end
    n_vec++;
    if (obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL simul_model: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_idle_timeout();
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    for (int i = 1; i <= TO; i++) begin
      step(0, 0, 0);
      n_vec++;
      if (timeout !== (TO_EN && i == TO)) begin
        n_err++;
        $display("FAIL timeout_at i%0d: got %b want %b",
                 i, timeout, TO_EN && i == TO);
      end
    end
    n_vec++;
    if (credit !== (TO_EN ? 4'd0 : 4'd1) || locked !== TO_EN) begin
      n_err++;
      $display("FAIL forfeit: got c%0d l%b want c%0d l%b",
               credit, locked, !TO_EN, TO_EN);
    end
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    for (int i = 1; i < TO; i++) begin
      step(0, 0, 0);
      n_vec++;
      if (timeout !== 1'b0 || credit !== 4'd1) begin
        n_err++;
        $display("FAIL early_to i%0d: got t%b c%0d want t0 c1",
                 i, timeout, credit);
      end
    end
    step(0, 0, 1);
    n_vec++;
    if (obs_vec() !== 12'h801) begin
      n_err++;
      $display("FAIL pass_before_to: got %h want 801", obs_vec());
    end
  endtask

  task automatic test_reset_mid_alarm();
    int tos;
    tos = 0;
    step(1, 0, 0);
    step(0, 0, 1);
    step(1, 0, 0);
    n_vec++;
    if (obs_vec() !== 12'h800) begin
      n_err++;
      $display("FAIL rst_alarm: got %h want 800", obs_vec());
    end
    step(0, 1, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    n_vec++;
    if (credit !== 4'd0) begin
      n_err++;
      $display("FAIL rst_partial: got %0d want 0", credit);
    end
    step(0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0);
      if (timeout === 1'b1) tos++;
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL idle20 i%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if (tos != int'(TO_EN) || credit !== (TO_EN ? 4'd0 : 4'd1)) begin
      n_err++;
      $display("FAIL idle20_end: got to%0d c%0d want to%0d c%0d",
               tos, credit, TO_EN, !TO_EN);
    end
  endtask

  task automatic test_random();
    bit quiet;
    bit c;
    bit p;
    bit r;
    quiet = 1'b0;
    step(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) quiet = ($urandom_range(0, 2) == 0);
      if (quiet) begin
        c = ($urandom_range(0, 11) == 0);
        p = ($urandom_range(0, 15) == 0);
      end else begin
        c = ($urandom_range(0, 2) == 0);
        p = ($urandom_range(0, 3) == 0);
      end
      r = ($urandom_range(0, 299) == 0);
      step(r, c, p);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random i%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    m_credit     = 0;
    m_acc        = 0;
    m_idle       = 0;
    m_pass       = 0;
    m_cyc        = 0;
    m_alarm_last = -1;
    m_rej        = 1'b0;
    m_to         = 1'b0;
    rst          = 1'b1;
    coin         = 1'b0;
    push         = 1'b0;
    test_reset();
    test_coin_price();
    test_saturation();
    test_back_to_back();
    test_idle_timeout();
    test_reset_mid_alarm();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
